quantize_q0_32: RTL and testbench
=================================

Name: quantize_q0_32

Overview:
- Inverse of the dequantizer: converts signed fixed-point activations back to the 8-bit unsigned quantized domain (uint8 with zero point) for the next conv/pool layer or the feature-map writeback buffer.
- Pipeline: scale by 1/S, round, add zero point, saturate.
- Streams one sample per cycle with valid/ready backpressure.
- Maintains a saturation event counter for calibration debug.

Parameters:
- FRAC_BITS, 16, number of fractional bits of in_data (signed Q(31-FRAC_BITS).FRAC_BITS); legal range 0..31.
- INV_SCALE, 32'd548973, unsigned Q16.16 reciprocal of the quantization scale (1/0.11937939375638962 * 2^16, rounded).
- ZERO_POINT, 8'd0, uint8 zero point added after rounding.
- CNT_W, 16, width of the saturation counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  32  signed fixed-point sample.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  8  quantized uint8 sample.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- sat_cnt  output  CNT_W  count of saturated samples.
- sat_clr  input  1  synchronous clear of sat_cnt.

Behaviour:
- One clock, clk. rst_n is asynchronous assert and active low.
- Reset state: all stage valid flags 0, all data registers 0, out_data=0, out_valid=0, sat_cnt=0.
- Reset mid-stream discards all in-flight samples. No output is produced for them.
- Pipeline enable: en = ~out_valid | out_ready. in_ready = en (combinational).
  - A transfer occurs when in_valid & in_ready. A transfer occurs at the output when out_valid & out_ready.
- When en=1, all three stages advance together. An empty input slot inserts a bubble (valid=0).
- When en=0, every stage holds its data and valid bit. out_data stays stable while out_valid=1 and out_ready=0.
- Latency: 3 cycles from accepted input to out_valid with no stall. Throughput is 1 sample/cycle.
- S1: register in_data and its valid bit.
- S2: product P = signed(in_data) * {1'b0, INV_SCALE}.
  - P is a 65-bit signed result with SH = FRAC_BITS+16 fractional bits.
- S3:
  - Rounding: R = (P + 2^(SH-1)) >>> SH, an arithmetic shift. This is round-half-up (toward +inf).
  - Add the zero point: Z = R + ZERO_POINT, evaluated in a signed width of at least 50 bits.
  - Saturate: out_data = 0 if Z<0; 255 if Z>255; otherwise Z[7:0].
  - sat flag = (Z<0) | (Z>255).
- sat_cnt:
  - Increments by 1 when a valid sample enters S3 (en=1) with the sat flag set.
  - Sticks at 2^CNT_W-1 and never wraps.
  - sat_clr=1 forces 0 on the next edge.
  - If sat_clr and an increment occur in the same cycle, clear wins (result 0).
- Boundary: in_data=0x80000000 (most negative) saturates to 0 without overflow. in_data=0x7FFFFFFF saturates to 255.
- Simultaneous output accept and input accept in the same cycle is legal and loses no sample.

Test Plan:
- Defaults, stream 0x00010000 (1.0), 0x001E0000 (30.0), 0x00001000 (0.0625) back-to-back with out_ready=1 → out_data 8, 251, 1 on three consecutive cycles, first valid 3 cycles after first accept; sat_cnt=0.
- Defaults, inputs 0x001F0000 (31.0) then 0xFFFF0000 (-1.0), plus 0x7FFFFFFF and 0x80000000 → outputs 255, 0, 255, 0; sat_cnt=4.
- INV_SCALE=32'd65536, ZERO_POINT=8'd128, inputs 0x00008000 (0.5), 0xFFFF8000 (-0.5), 0xFFFE8000 (-1.5) → 129, 128, 127 (round-half-up).
- Backpressure: stream 10 incrementing samples and toggle out_ready pseudo-randomly → outputs match a reference model in order with no drops or duplicates; out_data stable while stalled; in_ready=0 whenever out_valid=1 and out_ready=0.
- sat_cnt: CNT_W=2, feed 5 saturating samples → sat_cnt sticks at 3. Assert sat_clr in the same cycle a saturating sample reaches S3 → sat_cnt=0.
- Assert rst_n=0 asynchronously with 3 samples in flight → out_valid and sat_cnt drop to 0 immediately; after release, none of those samples appear; the next input emerges after 3 cycles.

Source files
------------

// File: rtl/quantize_q0_32.sv
`timescale 1ns/1ps
// quantize_q0_32
// Converts signed fixed-point activations (Q(31-FRAC_BITS).FRAC_BITS) to
// the uint8 quantized domain: multiply by the reciprocal scale, round
// half-up, add the zero point and saturate to 0..255. This is a
// three-stage pipeline with valid/ready backpressure. It also has a sticky
// saturation event counter for calibration debug.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    signed fixed-point sample
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle (combinational)
//   out_data   quantized uint8 sample
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data
//   sat_cnt    number of saturated samples, sticks at all-ones
//   sat_clr    synchronous clear of sat_cnt (wins over an increment)
module quantize_q0_32 #(
  parameter int unsigned FRAC_BITS  = 32'd16,
  parameter logic [31:0] INV_SCALE  = 32'd548973,
  parameter logic [7:0]  ZERO_POINT = 8'd0,
  parameter int unsigned CNT_W      = 32'd16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             sat_clr
);

  // Fractional bits of the product: input fraction plus the Q16.16 scale.
  localparam int unsigned SH = FRAC_BITS + 32'd16;
  // Half an LSB of the result, added before the floor shift (round half-up).
  localparam logic signed [65:0] HALF = 66'sd1 <<< (SH - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                    en_s;
  logic                    s1_valid_r;
  logic [31:0]             s1_data_r;
  logic                    s2_valid_r;
  logic signed [64:0]      s2_prod_r;
  logic                    out_valid_r;
  logic [7:0]              out_data_r;
  logic [CNT_W-1:0]        sat_cnt_r;

  logic signed [64:0]      prod_s;
  logic signed [65:0]      sum_s;
  logic signed [65:0]      rnd_s;
  logic signed [65:0]      z_s;
  logic [7:0]              sat_data_s;
  logic                    sat_s;

  // The whole pipeline moves together whenever the output slot can take a sample.
  assign en_s      = ~out_valid_r | out_ready;
  assign in_ready  = en_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign sat_cnt   = sat_cnt_r;

  // S2 multiply: both operands are widened to 65 bits. The product of a 32-bit
  // signed value and a 33-bit non-negative value always fits.
  always_comb begin
    prod_s = $signed({{33{s1_data_r[31]}}, s1_data_r}) * $signed({33'd0, INV_SCALE});
  end

  // S3 arithmetic: round half-up, add the zero point, clamp to uint8.
  // The 66-bit headroom keeps the most negative input from wrapping.
  always_comb begin
    sum_s = $signed({s2_prod_r[64], s2_prod_r}) + HALF;
    rnd_s = sum_s >>> SH;
    z_s   = rnd_s + $signed({58'd0, ZERO_POINT});
    if (z_s < 66'sd0) begin
      sat_s      = 1'b1;
      sat_data_s = 8'd0;
    end else if (z_s > 66'sd255) begin
      sat_s      = 1'b1;
      sat_data_s = 8'd255;
    end else begin
      sat_s      = 1'b0;
      sat_data_s = z_s[7:0];
    end
  end

  // Pipeline stages S1 (input capture), S2 (product) and S3 (registered output).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_data_r   <= 32'd0;
      s2_valid_r  <= 1'b0;
      s2_prod_r   <= 65'sd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'd0;
    end else if (en_s) begin
      s1_valid_r  <= in_valid;
      s1_data_r   <= in_data;
      s2_valid_r  <= s1_valid_r;
      s2_prod_r   <= prod_s;
      out_valid_r <= s2_valid_r;
      // A bubble leaves the last data word in place. Only out_valid moves.
      if (s2_valid_r) begin
        out_data_r <= sat_data_s;
      end else begin
        out_data_r <= out_data_r;
      end
    end else begin
      s1_valid_r  <= s1_valid_r;
      s1_data_r   <= s1_data_r;
      s2_valid_r  <= s2_valid_r;
      s2_prod_r   <= s2_prod_r;
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
    end
  end

  // Saturation event counter: counts valid saturating samples entering S3.
  // It sticks at all-ones, and clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_r <= {CNT_W{1'b0}};
    end else if (sat_clr) begin
      sat_cnt_r <= {CNT_W{1'b0}};
    end else if (en_s && s2_valid_r && sat_s && (sat_cnt_r != CNT_MAX)) begin
      sat_cnt_r <= sat_cnt_r + CNT_W'(1'b1);
    end else begin
      sat_cnt_r <= sat_cnt_r;
    end
  end

endmodule

// File: tb/tb_quantize_q0_32.sv
`timescale 1ns/1ps
// Self-checking bench for quantize_q0_32. Three instances share one stimulus
// stream. Instance a uses the defaults. Instance b uses a unit scale with
// zero point 128. Instance c uses a 2-bit saturation counter. Because the
// valid/ready timing does not depend on data, all three advance in lockstep.
module tb_quantize_q0_32;

  localparam int FB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        sat_clr;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic [7:0]  out_data_a, out_data_b, out_data_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [15:0] sat_cnt_a, sat_cnt_b;
  logic [1:0]  sat_cnt_c;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit         in_acc;
  bit         smp_ov;
  bit         smp_or;
  logic [7:0] smp_od;
  logic [2:0] smp_ir;

  logic [7:0] got_a[$], got_b[$], got_c[$];
  logic [7:0] exp_a[$], exp_b[$];
  int         acc_cyc[$], out_cyc[$];
  int         nsat_a, nsat_b;

  always #5 clk = ~clk;

  quantize_q0_32 dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .sat_cnt(sat_cnt_a), .sat_clr(sat_clr)
  );

  quantize_q0_32 #(.INV_SCALE(32'd65536), .ZERO_POINT(8'd128)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .sat_cnt(sat_cnt_b), .sat_clr(sat_clr)
  );

  quantize_q0_32 #(.CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_c), .out_data(out_data_c), .out_valid(out_valid_c),
    .out_ready(out_ready), .sat_cnt(sat_cnt_c), .sat_clr(sat_clr)
  );

  // Reference: value = in * inv / 2^(FB+16), rounded by floor(x + 0.5), plus zero point.
  function automatic longint ref_z(input logic [31:0] d, input longint inv, input longint zp);
    longint dv, dvsr, num, r;
    dv   = longint'($signed(d));
    dvsr = longint'(1) << (FB + 16);
    num  = dv * inv + dvsr / 2;
    r    = num / dvsr;
    if ((num % dvsr != 0) && (num < 0)) r = r - 1;
    return r + zp;
  endfunction

  function automatic logic [7:0] clamp8(input longint z);
    if (z < 0) return 8'd0;
    else if (z > 255) return 8'd255;
    else return 8'(z);
  endfunction

  task automatic model_push(input logic [31:0] d);
    longint za, zb;
    za = ref_z(d, 548973, 0);
    zb = ref_z(d, 65536, 128);
    exp_a.push_back(clamp8(za));
    exp_b.push_back(clamp8(zb));
    if (za < 0 || za > 255) nsat_a++;
    if (zb < 0 || zb > 255) nsat_b++;
  endtask

  // One clock: sample at the falling edge, then return 1 ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    smp_ov = out_valid_a;
    smp_od = out_data_a;
    smp_or = out_ready;
    smp_ir = {in_ready_a, in_ready_b, in_ready_c};
    in_acc = in_valid && in_ready_a;
    if (in_acc) acc_cyc.push_back(cyc);
    if (out_valid_a && out_ready) begin
      got_a.push_back(out_data_a);
      out_cyc.push_back(cyc);
    end
    if (out_valid_b && out_ready) got_b.push_back(out_data_b);
    if (out_valid_c && out_ready) got_c.push_back(out_data_c);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!in_acc && n < 200);
    checks++;
    if (!in_acc) begin
      failures++;
      $display("FAIL send_timeout: sample %h not accepted within %0d cycles", d, n);
    end else begin
      model_push(d);
    end
  endtask

  task automatic drain(input int k);
    in_valid = 1'b0;
    repeat (k) tick();
  endtask

  task automatic clear_all();
    got_a.delete(); got_b.delete(); got_c.delete();
    exp_a.delete(); exp_b.delete();
    acc_cyc.delete(); out_cyc.delete();
    nsat_a = 0;
    nsat_b = 0;
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1; sat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid_a !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a); end
    checks++;
    if (out_data_a !== 8'd0) begin failures++; $display("FAIL reset_out_data: got %0d want 0", out_data_a); end
    checks++;
    if (sat_cnt_a !== 16'd0 || sat_cnt_c !== 2'd0) begin
      failures++; $display("FAIL reset_sat_cnt: got %0d/%0d want 0", sat_cnt_a, sat_cnt_c);
    end
    checks++;
    if (in_ready_a !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready_a); end
  endtask

  task automatic test_stream();
    logic [7:0] k[3];
    k[0] = 8'd8; k[1] = 8'd251; k[2] = 8'd1;
    clear_all();
    send(32'h0001_0000); send(32'h001E_0000); send(32'h0000_1000);
    drain(6);
    checks++;
    if (got_a.size() != 3) begin
      failures++; $display("FAIL stream_count: got %0d samples want 3", got_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_a[i] !== k[i] || got_a[i] !== exp_a[i]) begin
          failures++; $display("FAIL stream_data[%0d]: got %0d want %0d", i, got_a[i], k[i]);
        end
      end
      checks++;
      if (out_cyc[0] - acc_cyc[0] != 3) begin
        failures++; $display("FAIL stream_latency: got %0d want 3", out_cyc[0] - acc_cyc[0]);
      end
      checks++;
      if (out_cyc[2] - out_cyc[0] != 2) begin
        failures++; $display("FAIL stream_throughput: span %0d want 2", out_cyc[2] - out_cyc[0]);
      end
    end
    checks++;
    if (sat_cnt_a !== 16'd0) begin failures++; $display("FAIL stream_sat_cnt: got %0d want 0", sat_cnt_a); end
  endtask

  task automatic test_saturation();
    logic [7:0] k[4];
    k[0] = 8'd255; k[1] = 8'd0; k[2] = 8'd255; k[3] = 8'd0;
    clear_all();
    send(32'h001F_0000); send(32'hFFFF_0000); send(32'h7FFF_FFFF); send(32'h8000_0000);
    drain(6);
    checks++;
    if (got_a.size() != 4) begin
      failures++; $display("FAIL sat_count: got %0d samples want 4", got_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_a[i] !== k[i]) begin
          failures++; $display("FAIL sat_data[%0d]: got %0d want %0d", i, got_a[i], k[i]);
        end
      end
    end
    checks++;
    if (sat_cnt_a !== 16'd4) begin failures++; $display("FAIL sat_cnt_a: got %0d want 4", sat_cnt_a); end
    checks++;
    if (sat_cnt_c !== 2'd3) begin failures++; $display("FAIL sat_cnt_c_4: got %0d want 3", sat_cnt_c); end
  endtask

  task automatic test_sticky();
    clear_all();
    checks++;
    if (sat_cnt_a !== 16'd0 || sat_cnt_c !== 2'd0) begin
      failures++; $display("FAIL sat_clr: got %0d/%0d want 0", sat_cnt_a, sat_cnt_c);
    end
    for (int i = 0; i < 5; i++) send((i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000);
    drain(6);
    checks++;
    if (sat_cnt_c !== 2'd3) begin failures++; $display("FAIL sticky_c: got %0d want 3", sat_cnt_c); end
    checks++;
    if (sat_cnt_a !== 16'd5) begin failures++; $display("FAIL sticky_a: got %0d want 5", sat_cnt_a); end
  endtask

  task automatic test_round();
    logic [7:0] k[3];
    k[0] = 8'd129; k[1] = 8'd128; k[2] = 8'd127;
    clear_all();
    send(32'h0000_8000); send(32'hFFFF_8000); send(32'hFFFE_8000);
    drain(6);
    checks++;
    if (got_b.size() != 3) begin
      failures++; $display("FAIL round_count: got %0d samples want 3", got_b.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_b[i] !== k[i] || got_b[i] !== exp_b[i]) begin
          failures++; $display("FAIL round_data[%0d]: got %0d want %0d", i, got_b[i], k[i]);
        end
      end
    end
  endtask

  task automatic test_clr_collision();
    clear_all();
    send(32'h7FFF_FFFF);
    in_valid = 1'b0;
    tick();
    sat_clr = 1'b1;   // the saturating sample enters S3 on this edge
    tick();
    sat_clr = 1'b0;
    drain(3);
    checks++;
    if (sat_cnt_a !== 16'd0 || sat_cnt_c !== 2'd0) begin
      failures++; $display("FAIL clr_collision: got %0d/%0d want 0", sat_cnt_a, sat_cnt_c);
    end
    checks++;
    if (got_a.size() != 1 || got_a[0] !== 8'd255) begin
      failures++; $display("FAIL clr_collision_data: got %0d samples want one 255", got_a.size());
    end
  endtask

  task automatic test_back_to_back(input int n, input bit rnd);
    int i = 0;
    int guard = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_od = 8'd0;
    logic [31:0] cur;
    int v;
    clear_all();
    cur = 32'd0;
    while ((i < n || got_a.size() < n) && guard < 3000) begin
      if (rnd && i < n && !in_valid) begin
        v = int'($urandom_range(0, 32'h003F_FFFF)) - 32'sh0020_0000;
        cur = ($urandom_range(0, 3) == 0) ? $urandom : 32'(v);
      end else if (!rnd) begin
        cur = 32'(i) * 32'h0001_0000;
      end
      in_valid  = (i < n) && ($urandom_range(0, 3) != 0);
      in_data   = cur;
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      guard++;
      if (in_acc) begin
        model_push(cur);
        i++;
        in_valid = 1'b0;
      end
      if (prev_stall) begin
        checks++;
        if (!(smp_ov === 1'b1 && smp_od === prev_od)) begin
          failures++; $display("FAIL stall_hold: valid %b data %0d want 1/%0d", smp_ov, smp_od, prev_od);
        end
      end
      if (smp_ov && !smp_or) begin
        checks++;
        if (smp_ir !== 3'b000) begin
          failures++; $display("FAIL stall_in_ready: got %b want 000", smp_ir);
        end
      end
      prev_stall = smp_ov && !smp_or;
      prev_od    = smp_od;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(4);
    checks++;
    if (guard >= 3000) begin failures++; $display("FAIL bp_timeout: %0d of %0d sent", i, n); end
    checks++;
    if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size() || got_c.size() != exp_a.size()) begin
      failures++;
      $display("FAIL bp_count: got %0d/%0d/%0d want %0d", got_a.size(), got_b.size(), got_c.size(), exp_a.size());
    end else begin
      for (int j = 0; j < exp_a.size(); j++) begin
        checks++;
        if (got_a[j] !== exp_a[j] || got_b[j] !== exp_b[j] || got_c[j] !== exp_a[j]) begin
          failures++;
          $display("FAIL bp_data[%0d]: got %0d/%0d/%0d want %0d/%0d", j, got_a[j], got_b[j], got_c[j], exp_a[j], exp_b[j]);
        end
      end
    end
    checks++;
    if (sat_cnt_a !== 16'(nsat_a) || sat_cnt_b !== 16'(nsat_b) || sat_cnt_c !== 2'((nsat_a > 3) ? 3 : nsat_a)) begin
      failures++;
      $display("FAIL bp_sat_cnt: got %0d/%0d/%0d want %0d/%0d", sat_cnt_a, sat_cnt_b, sat_cnt_c, nsat_a, nsat_b);
    end
  endtask

  task automatic test_async_reset();
    clear_all();
    send(32'h7FFF_FFFF); send(32'h0001_0000); send(32'h0002_0000);
    in_valid = 1'b0;
    checks++;
    if (out_valid_a !== 1'b1 || sat_cnt_a !== 16'd1) begin
      failures++; $display("FAIL arst_pre: valid %b cnt %0d want 1/1", out_valid_a, sat_cnt_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_a !== 1'b0 || sat_cnt_a !== 16'd0 || sat_cnt_c !== 2'd0) begin
      failures++; $display("FAIL arst_immediate: valid %b cnt %0d want 0/0", out_valid_a, sat_cnt_a);
    end
    tick(); tick();
    rst_n = 1'b1;
    clear_all();
    drain(6);
    checks++;
    if (got_a.size() != 0) begin failures++; $display("FAIL arst_ghost: got %0d samples want 0", got_a.size()); end
    send(32'h0001_0000);
    drain(5);
    checks++;
    if (got_a.size() != 1 || got_a[0] !== 8'd8 || out_cyc[0] - acc_cyc[0] != 3) begin
      failures++; $display("FAIL arst_next: got %0d samples want one 8 after 3 cycles", got_a.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_saturation();
    test_sticky();
    test_round();
    test_clr_collision();
    test_back_to_back(10, 1'b0);
    test_back_to_back(40, 1'b1);
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
